// File: rtl/sequence_fetch_if.sv
// Digit stream handshake between sequence_fetch and its consumer.
// The master drives digit/digitValid; the slave answers with digitReady.
interface sequence_fetch_if #(
  parameter int DIGIT_W = 4
);
  logic [DIGIT_W-1:0] digit;
  logic               digitValid;
  logic               digitReady;

  modport master (
    output digit,
    output digitValid,
    input  digitReady
  );

  modport slave (
    input  digit,
    input  digitValid,
    output digitReady
  );
endinterface

// File: rtl/sequence_fetch.sv
// Reads one stored sequence by index from the sequence RAM and
// presents it as a whole word and as an MSB-first digit stream.
module sequence_fetch #(
  parameter int DATA_W  = 20,
  parameter int ADDR_W  = 5,
  parameter int DIGIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] fetchAddr,
  input  logic [ADDR_W:0]   wrCount,
  input  logic [DATA_W-1:0] RAM_data,
  output logic [ADDR_W-1:0] RAM_addr,
  output logic              RAM_R,
  output logic [DATA_W-1:0] Seq_out,
  output logic              seqValid,
  output logic              busy,
  output logic              err,
  sequence_fetch_if.master  dq
);

  localparam int NDIG   = DATA_W / DIGIT_W;
  localparam int REST_W = DATA_W - DIGIT_W;
  localparam int CNT_W  = $clog2(NDIG);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    SHIFT
  } state_t;

  state_t             state;
  logic [REST_W-1:0]  rest;
  logic [CNT_W-1:0]   cnt;
  logic               in_range;

  // Extend the index so a full store (count 32) still compares correctly.
  assign in_range = {1'b0, fetchAddr} < wrCount;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      RAM_addr      <= '0;
      RAM_R         <= 1'b0;
      Seq_out       <= '0;
      seqValid      <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      rest          <= '0;
      cnt           <= '0;
      dq.digit      <= '0;
      dq.digitValid <= 1'b0;
    end else begin
      seqValid <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fetch) begin
            if (in_range) begin
              RAM_addr <= fetchAddr;
              RAM_R    <= 1'b1;
              busy     <= 1'b1;
              state    <= READ;
            end else begin
              err <= 1'b1;
            end
          end
        end
        READ: begin
          RAM_R <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          Seq_out       <= RAM_data;
          seqValid      <= 1'b1;
          dq.digit      <= RAM_data[DATA_W-1 -: DIGIT_W];
          rest          <= RAM_data[REST_W-1:0];
          dq.digitValid <= 1'b1;
          cnt           <= '0;
          state         <= SHIFT;
        end
        SHIFT: begin
          if (dq.digitReady) begin
            if (cnt == LAST) begin
              dq.digitValid <= 1'b0;
              busy          <= 1'b0;
              state         <= IDLE;
            end else begin
              dq.digit <= rest[REST_W-1 -: DIGIT_W];
              rest     <= rest << DIGIT_W;
              cnt      <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_fetch.sv
// Self-checking bench for sequence_fetch: directed cases plus
// randomized fetches against a word/digit-level reference model.
module tb_sequence_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch = 1'b0;
  logic [4:0]  fetchAddr = '0;
  logic [5:0]  wrCount = '0;
  logic [19:0] RAM_data = '0;
  logic [4:0]  RAM_addr;
  logic        RAM_R;
  logic [19:0] Seq_out;
  logic        seqValid;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [19:0] mem [32];
  logic [19:0] last_seq = '0;

  sequence_fetch_if #(.DIGIT_W(4)) dq ();

  sequence_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fetch),
    .fetchAddr (fetchAddr),
    .wrCount   (wrCount),
    .RAM_data  (RAM_data),
    .RAM_addr  (RAM_addr),
    .RAM_R     (RAM_R),
    .Seq_out   (Seq_out),
    .seqValid  (seqValid),
    .busy      (busy),
    .err       (err),
    .dq        (dq)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model
  always @(posedge clk)
    if (RAM_R) RAM_data <= mem[RAM_addr];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] nib(input logic [19:0] w, input int i);
    return 4'((w >> (4 * (4 - i))) & 20'hF);
  endfunction

  // mode 0: ready always; 1: random ready; 2: 3-cycle stall on digit 2
  task automatic run_fetch(input logic [4:0] a, input int wc,
                           input int mode, input bit hold);
    logic [19:0] exp;
    int idx, cyc, lows;
    bit r, xfer;
    exp = mem[a];
    fetch = 1'b1;
    fetchAddr = a;
    wrCount = 6'(wc);
    step();
    fetch = 1'b0;
    wrCount = 6'($urandom_range(0, 32));
    if (!(int'(a) < wc)) begin
      check("rej_err", err, 1);
      check("rej_busy", busy, 0);
      check("rej_ramr", RAM_R, 0);
      step();
      check("rej_err_pulse", err, 0);
      check("rej_ramr2", RAM_R, 0);
      check("rej_seq", Seq_out, last_seq);
      return;
    end
    check("e0_ramr", RAM_R, 1);
    check("e0_addr", RAM_addr, a);
    check("e0_busy", busy, 1);
    check("e0_err", err, 0);
    step();
    check("e1_ramr", RAM_R, 0);
    check("e1_seqv", seqValid, 0);
    step();
    check("e2_seqv", seqValid, 1);
    check("e2_seq", Seq_out, exp);
    check("e2_dvalid", dq.digitValid, 1);
    last_seq = exp;
    idx = 0;
    cyc = 0;
    lows = 0;
    while (idx < 5 && cyc < 200) begin
      case (mode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 99) < 60);
        default: r = !(idx == 1 && lows < 3);
      endcase
      dq.digitReady = r;
      if (hold) begin
        fetch = 1'b1;
        fetchAddr = 5'd1;
        wrCount = 6'd32;
      end
      xfer = dq.digitValid && r;
      if (!r) lows++;
      if (xfer) check($sformatf("digit%0d", idx), dq.digit, nib(exp, idx));
      step();
      cyc++;
      if (xfer) idx++;
      check("shift_busy", busy, (idx < 5) ? 1 : 0);
      check("shift_ramr", RAM_R, 0);
      check("shift_seqv", seqValid, 0);
    end
    check("digit_count", idx, 5);
    check("xfer_cycles", cyc, 5 + lows);
    check("end_dvalid", dq.digitValid, 0);
    fetch = 1'b0;
    dq.digitReady = 1'b0;
  endtask

  initial begin
    dq.digitReady = 1'b0;
    foreach (mem[i]) mem[i] = 20'($urandom);
    mem[0]  = 20'h74DBA;
    mem[1]  = 20'h1C0DE;
    mem[3]  = 20'h58EA3;
    mem[31] = 20'hFFFFF;

    #2;
    check("rst_seq", Seq_out, 0);
    check("rst_addr", RAM_addr, 0);
    check("rst_ramr", RAM_R, 0);
    check("rst_busy", busy, 0);
    check("rst_dvalid", dq.digitValid, 0);
    #10 rst = 1'b1;
    step();

    run_fetch(5'd3, 4, 0, 0);
    run_fetch(5'd0, 4, 2, 0);
    run_fetch(5'd4, 4, 0, 0);
    run_fetch(5'd0, 0, 0, 0);
    run_fetch(5'd3, 4, 0, 1);
    run_fetch(5'd1, 4, 0, 0);
    run_fetch(5'd31, 32, 0, 0);

    // Reset mid-SHIFT
    fetch = 1'b1;
    fetchAddr = 5'd3;
    wrCount = 6'd4;
    step();
    fetch = 1'b0;
    step();
    step();
    step();
    check("pre_rst_dvalid", dq.digitValid, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_seq", Seq_out, 0);
    check("arst_digit", dq.digit, 0);
    check("arst_dvalid", dq.digitValid, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", RAM_addr, 0);
    last_seq = '0;
    @(negedge clk);
    rst = 1'b1;
    dq.digitReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_dvalid", dq.digitValid, 0);
      check("post_rst_busy", busy, 0);
    end
    dq.digitReady = 1'b0;

    for (int n = 0; n < 40; n++) begin
      int wc;
      logic [4:0] a;
      wc = $urandom_range(0, 32);
      a = 5'($urandom_range(0, 31));
      mem[a] = 20'($urandom);
      run_fetch(a, wc, 1, 0);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_fetch.md
# sequence_fetch

Read-side companion to the sequence store. It retrieves a stored 20-bit sequence from the shared 32 x 20 sequence RAM by index and presents it two ways: whole, as a one-cycle-valid word, and as five 4-bit digits, most significant first, under a valid/ready handshake for the display and playback logic. It owns the RAM read port: `RAM_addr` and `RAM_R`. It checks each index against the store's current entry count and refuses out-of-range requests.

## Interface
- `DATA_W`, 20, sequence width; must be a multiple of `DIGIT_W`
- `ADDR_W`, 5, RAM address width (32 entries)
- `DIGIT_W`, 4, digit width; `DATA_W/DIGIT_W` = 5 digits
- `clk` in 1: single clock; all state changes on rising edge
- `rst` in 1: asynchronous, active-low reset
- `fetch` in 1: request; sampled only in IDLE
- `fetchAddr` in `ADDR_W`: index to read; sampled with `fetch`
- `wrCount` in `ADDR_W+1`: number of valid entries (0..32), driven by the store
- `RAM_data` in `DATA_W`: synchronous RAM read data, valid the cycle after the RAM samples `RAM_addr`/`RAM_R`
- `RAM_addr` out `ADDR_W`: registered read address
- `RAM_R` out 1: registered read enable
- `Seq_out` out `DATA_W`: last fetched sequence; holds until the next successful fetch
- `seqValid` out 1: one-cycle pulse when `Seq_out` updates
- `digit` out `DIGIT_W`: current digit
- `digitValid` out 1: `digit` is valid
- `digitReady` in 1: consumer accepts `digit` at an edge where `digitValid & digitReady`
- `busy` out 1: high from request acceptance until the last digit transfer
- `err` out 1: one-cycle pulse on a rejected request

## Operation
- Reset (async, `rst`=0): state is IDLE. Every output goes to 0, including `Seq_out`, `RAM_addr` and `RAM_R`. The digit counter clears. Reset mid-operation abandons the fetch immediately; no partial digits are emitted after release.
- States: IDLE, READ, WAIT, SHIFT.
- IDLE:
  - On `fetch`=1 with `fetchAddr < wrCount`: `RAM_addr` <= `fetchAddr`, `RAM_R` <= 1, `busy` <= 1, go to READ.
  - On `fetch`=1 with `fetchAddr >= wrCount`: `err` <= 1 for one cycle. No RAM access; stay IDLE. If `wrCount`=0, every request errors.
- READ: `RAM_R` <= 0; go to WAIT. `RAM_addr` holds.
- WAIT:
  - `Seq_out` <= `RAM_data`, `seqValid` <= 1 for one cycle.
  - Load the shift register with `RAM_data`, `digit` <= `RAM_data[19:16]`, `digitValid` <= 1, counter <= 0.
  - Go to SHIFT.
- SHIFT:
  - On each edge with `digitReady`=1 and counter < 4: shift left by 4, `digit` <= next nibble, counter++.
  - On the edge with `digitReady`=1 and counter = 4: `digitValid` <= 0, `busy` <= 0, go to IDLE.
  - With `digitReady`=0: `digit`, `digitValid` and counter hold, with no limit on the stall.
- `fetch` is ignored outside IDLE, including on the final-transfer edge; it is accepted from the following edge onward.
- `wrCount` is sampled only at acceptance. Later changes do not affect an in-flight fetch.
- `digitReady` is ignored when `digitValid`=0.

## Timing
- E0 = the edge that accepts `fetch`.
- `RAM_R`=1 and `RAM_addr` valid for the cycle E0..E1. The RAM samples at E1.
- `Seq_out`/`seqValid` update at E2. Latency from request to word is 2 cycles.
- First `digit` is valid at E2. With `digitReady` held high, the digits transfer at E3..E7 and `busy` falls at E7.
- Minimum request-to-request spacing is 8 cycles. Each cycle `digitReady` is low adds one.
- Reject path: `err` is high for the cycle after E0 only; `busy` stays 0.

## Test plan
- Reset: assert `rst`=0 mid-SHIFT -> all outputs 0 immediately. After release, no digit pulses occur until a new `fetch`.
- Basic fetch: RAM[3]=20'h58EA3, `wrCount`=4, `fetch` with `fetchAddr`=3, `digitReady`=1 -> `RAM_addr`=3 with `RAM_R` high for 1 cycle; `Seq_out`=20'h58EA3 with `seqValid` at E2; digits 5,8,E,A,3 at E3..E7; `busy` low after E7.
- Backpressure: RAM[0]=20'h74DBA, `digitReady` low for 3 cycles after the second digit -> `digit`=4 is held for those cycles; the sequence 7,4,D,B,A completes 3 cycles late with no digit lost or duplicated.
- Range check: `wrCount`=4, `fetchAddr`=4 -> single `err` pulse, `RAM_R` never asserted, `Seq_out` unchanged. Same result with `wrCount`=0 and `fetchAddr`=0.
- Busy lockout: a second `fetch` (`fetchAddr`=1) during SHIFT -> ignored. The same request issued the cycle after `busy` falls -> accepted, `RAM_addr`=1.
- Boundary index: `wrCount`=32, `fetchAddr`=31, RAM[31]=20'hFFFFF -> five digits F. There is no overflow in the comparison.
